pokey_audio_timer: RTL and testbench
====================================

# pokey_audio_timer

Timer/divider controller for the four POKEY audio channels.
- Generates the 64 kHz and 15 kHz base-clock strobes from the machine clock.
- Holds the AUDF1–4 and AUDCTL registers and sequences reload/decrement of the four channel down-counters, including 16-bit joined modes and STIMER restart.
- Emits one-cycle underflow ticks that clock the per-channel polynomial/output stages downstream.
- Sits between the CPU register-write decode and the channel output logic.

## Interface
Parameters
- DIV64, 28, machine-clock cycles per 64 kHz base strobe
- DIV15, 114, machine-clock cycles per 15 kHz base strobe

Ports
- clk  in  1  machine clock (1.79 MHz); all state updates on the falling edge
- nRst  in  1  reset, asynchronous, active-low
- wr_en  in  1  register write strobe, sampled on a falling edge
- wr_addr  in  4  0/2/4/6 = AUDF1/2/3/4, 8 = AUDCTL, 9 = STIMER; other addresses ignored
- wr_data  in  8  write data
- tick  out  4  per-channel underflow pulse, one clk cycle wide
- base64  out  1  64 kHz strobe, one cycle wide
- base15  out  1  15 kHz strobe, one cycle wide

## Operation
- **Reset:**
  - AUDF1–4 = 0, AUDCTL = 0, prescalers = 0, counters = 0.
  - tick, base64 and base15 are 0 while nRst is low.
- **Prescalers:**
  - Free-running modulo-DIV64 and modulo-DIV15 counters.
  - A strobe is asserted on the cycle the counter wraps to 0.
  - Prescalers are not affected by STIMER.
- **Channel clock enable:**
  - Default source is base64, or base15 if AUDCTL[0] = 1.
  - Ch1 uses every clk when AUDCTL[6] = 1.
  - Ch3 uses every clk when AUDCTL[5] = 1.
- **Counters:** 9-bit down-counters. On each enable:
  - if count = 0: reload and pulse tick;
  - otherwise: decrement.
- **Reload values (single channel):**
  - AUDF when clocked from a base strobe; period = AUDF+1 strobes.
  - AUDF+3 when clocked at 1.79 MHz; period = AUDF+4 cycles.
- **Joined pair 1+2 (AUDCTL[4]) and 3+4 (AUDCTL[3]):**
  - One 17-bit counter with value {AUDFhi, AUDFlo}.
  - Clocked by the low channel's enable.
  - Reload = value (base clock) or value+6 (1.79 MHz); 1.79 MHz period = value+7 cycles.
  - Underflow pulses the high channel's tick.
  - The low channel's tick is held 0.
- **AUDF write:** affects only the next reload; the current count is untouched.
- **AUDCTL write:** enable/join selection changes from the next cycle; counts are not modified.
- **STIMER write (any data):**
  - All counters load their reload values on that edge.
  - No tick on that edge.
  - STIMER takes priority over a coincident underflow.

## Timing
- tick is registered: high for exactly the one cycle following the edge on which the reload occurs.
- base64 first pulses DIV64 cycles after reset release; base15 first pulses DIV15 cycles after reset release.
- Write-to-effect latency is 1 edge (the register is updated on the write edge).
- After reset, counters at 0 produce a tick on the first enable.
- Deasserting nRst mid-count clears all state asynchronously; there are no partial pulses.

## Structure
- **Package `pokey_pkg`:** register address constants, AUDCTL bit indices (CLK15, CH1_FAST, CH3_FAST, JOIN12, JOIN34), DIV64/DIV15 defaults, and 1.79 MHz reload offsets (3, 6).
- **Sub-module `pokey_chan_cnt`:** 9-bit loadable down-counter with enable, load, reload value and zero flag.
  - Instantiated four times.
  - Joined mode cascades the low counter's zero flag into the high counter's enable, with the low counter reload handled by the parent.

## Test plan
1. Reset, write AUDF1 = 3, AUDCTL = 0x00 → tick[0] every 112 clk cycles (4×28).
2. AUDCTL = 0x01, AUDF2 = 0 → tick[1] every 114 cycles; base15 aligned with each tick.
3. AUDCTL = 0x40, AUDF1 = 0 → tick[0] every 4 cycles; AUDF1 = 0xFF → period 259.
4. AUDCTL = 0x50, AUDF1 = 0x00, AUDF2 = 0x01 → tick[1] every 263 cycles; tick[0] constantly 0.
5. STIMER written on the same edge as a ch3 underflow → no tick on that edge; the next tick[2] arrives a full period later; all four channels realigned.
6. nRst pulled low mid-count with AUDF = 0x10 → all outputs 0 immediately; after release, the first tick follows the first enable (count 0).

Source files
------------

// File: rtl/pokey_pkg.sv
// Shared constants for the POKEY audio timer: register map, AUDCTL bits,
// prescaler defaults and the 1.79 MHz reload offsets.
package pokey_pkg;

  localparam int unsigned DIV64_DEF = 28;
  localparam int unsigned DIV15_DEF = 114;
  localparam int unsigned CNT_W     = 9;
  localparam int unsigned JOIN_W    = 17;

  localparam logic [3:0] ADDR_AUDF1  = 4'd0;
  localparam logic [3:0] ADDR_AUDF2  = 4'd2;
  localparam logic [3:0] ADDR_AUDF3  = 4'd4;
  localparam logic [3:0] ADDR_AUDF4  = 4'd6;
  localparam logic [3:0] ADDR_AUDCTL = 4'd8;
  localparam logic [3:0] ADDR_STIMER = 4'd9;

  localparam int unsigned CLK15    = 0;
  localparam int unsigned JOIN34   = 3;
  localparam int unsigned JOIN12   = 4;
  localparam int unsigned CH3_FAST = 5;
  localparam int unsigned CH1_FAST = 6;

  localparam logic [CNT_W-1:0]  FAST_OFS_SINGLE = CNT_W'(3);
  localparam logic [JOIN_W-1:0] FAST_OFS_JOINED = JOIN_W'(6);

  // Only the AUDCTL bits this block acts on are held.
  typedef struct packed {
    logic ch1_fast;
    logic ch3_fast;
    logic join12;
    logic join34;
    logic clk15;
  } audctl_t;

endpackage

// File: rtl/pokey_chan_cnt.sv
// 9-bit loadable down-counter; load wins over enable, zero flag is combinational.
module pokey_chan_cnt
  import pokey_pkg::*;
(
  input  logic             clk,
  input  logic             nRst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst)     cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt - CNT_W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/pokey_audio_timer.sv
// POKEY audio timer: base-clock prescalers, AUDF/AUDCTL registers and the
// four channel down-counters with 16-bit joining and STIMER restart.
module pokey_audio_timer
  import pokey_pkg::*;
#(
  parameter int unsigned DIV64 = DIV64_DEF,
  parameter int unsigned DIV15 = DIV15_DEF
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] tick,
  output logic       base64,
  output logic       base15
);

  localparam int unsigned P64_W = $clog2(DIV64 + 1);
  localparam int unsigned P15_W = $clog2(DIV15 + 1);

  logic [P64_W-1:0] p64;
  logic [P15_W-1:0] p15;
  logic             wrap64_c, wrap15_c;
  logic [7:0]       audf [4];
  audctl_t          audctl;
  logic             stimer_c, base_en_c;
  logic [3:0]       en_c, fast_c, zero_c, cnt_en, cnt_ld, tick_c;
  logic [1:0]       join_c;
  logic [CNT_W-1:0] load_val [4];
  logic [JOIN_W-1:0] jval_c;

  assign wrap64_c = (p64 == P64_W'(DIV64 - 1));
  assign wrap15_c = (p15 == P15_W'(DIV15 - 1));

  // Free-running prescalers; strobe registered on the wrap edge.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      p64    <= '0;
      p15    <= '0;
      base64 <= 1'b0;
      base15 <= 1'b0;
    end else begin
      p64    <= wrap64_c ? '0 : p64 + P64_W'(1);
      p15    <= wrap15_c ? '0 : p15 + P15_W'(1);
      base64 <= wrap64_c;
      base15 <= wrap15_c;
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < 4; i++) audf[i] <= '0;
      audctl <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_AUDF1:  audf[0] <= wr_data;
        ADDR_AUDF2:  audf[1] <= wr_data;
        ADDR_AUDF3:  audf[2] <= wr_data;
        ADDR_AUDF4:  audf[3] <= wr_data;
        ADDR_AUDCTL: audctl  <= '{ch1_fast: wr_data[CH1_FAST], ch3_fast: wr_data[CH3_FAST],
                                   join12:   wr_data[JOIN12],   join34:   wr_data[JOIN34],
                                   clk15:    wr_data[CLK15]};
        default: ;
      endcase
    end
  end

  assign stimer_c  = wr_en && (wr_addr == ADDR_STIMER);
  assign base_en_c = audctl.clk15 ? wrap15_c : wrap64_c;
  assign en_c      = {base_en_c, audctl.ch3_fast | base_en_c, base_en_c, audctl.ch1_fast | base_en_c};
  assign fast_c    = {1'b0, audctl.ch3_fast, 1'b0, audctl.ch1_fast};
  assign join_c    = {audctl.join34, audctl.join12};

  // Reload/enable sequencing; joined pairs act as one counter spread over
  // two 9-bit halves, the low half refilling with 255 while the high half borrows.
  always_comb begin
    cnt_en = '0;
    cnt_ld = '0;
    tick_c = '0;
    jval_c = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_en[i]   = en_c[i];
      cnt_ld[i]   = stimer_c | (en_c[i] & zero_c[i]);
      load_val[i] = fast_c[i] ? CNT_W'(audf[i]) + FAST_OFS_SINGLE : CNT_W'(audf[i]);
      tick_c[i]   = en_c[i] & zero_c[i] & ~stimer_c;
    end
    for (int p = 0; p < 2; p++) begin
      if (join_c[p]) begin
        jval_c = JOIN_W'({audf[2*p+1], audf[2*p]}) + (fast_c[2*p] ? FAST_OFS_JOINED : '0);
        cnt_en[2*p+1]   = en_c[2*p] & zero_c[2*p];
        cnt_ld[2*p]     = stimer_c | (en_c[2*p] & zero_c[2*p]);
        cnt_ld[2*p+1]   = stimer_c | (en_c[2*p] & zero_c[2*p] & zero_c[2*p+1]);
        load_val[2*p]   = (stimer_c | zero_c[2*p+1]) ? CNT_W'(jval_c[7:0]) : CNT_W'(255);
        load_val[2*p+1] = jval_c[16:8];
        tick_c[2*p]     = 1'b0;
        tick_c[2*p+1]   = en_c[2*p] & zero_c[2*p] & zero_c[2*p+1] & ~stimer_c;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    pokey_chan_cnt u_cnt (
      .clk      (clk),
      .nRst     (nRst),
      .en       (cnt_en[g]),
      .load     (cnt_ld[g]),
      .load_val (load_val[g]),
      .zero_c   (zero_c[g])
    );
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) tick <= '0;
    else       tick <= tick_c;
  end

endmodule

// File: tb/tb_pokey_audio_timer.sv
// Directed bench for pokey_audio_timer: periods, joined mode, STIMER and reset.
module tb_pokey_audio_timer;

  logic       clk = 1'b0;
  logic       nRst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] tick;
  logic       base64, base15;

  int checks = 0;
  int errors = 0;
  int lo_hits;
  logic b15_at_tick;

  pokey_audio_timer #(.DIV64(28), .DIV15(114)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .tick    (tick),
    .base64  (base64),
    .base15  (base15)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input string tag);
    int n = 0;
    do begin @(posedge clk); n++; end while (!tick[ch] && n < 2000);
    if (!tick[ch]) check_eq({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  // Sync to one tick, then count cycles to the next one.
  task automatic measure(input int ch, input int exp, input string tag);
    int n = 0;
    wait_tick(ch, tag);
    lo_hits = 0;
    do begin
      @(posedge clk); n++;
      if (tick[0]) lo_hits++;
    end while (!tick[ch] && n < 2000);
    b15_at_tick = base15;
    check_eq(tag, 32'(n), 32'(exp));
  endtask

  // Release reset just after a rising edge and time the first strobes.
  task automatic release_check(input string tag);
    int n = 0;
    int early = 0;
    int n64 = 0;
    logic [3:0] t64 = '0;
    @(posedge clk); #1 nRst = 1'b1;
    do begin
      @(posedge clk); n++;
      if (base64 && n64 == 0) begin n64 = n; t64 = tick; end
      else if (n64 == 0 && tick != 4'h0) early++;
    end while (!base15 && n < 300);
    check_eq({tag, "_base64_first"}, 32'(n64), 32'(28));
    check_eq({tag, "_tick_first"}, 32'(t64), 32'(4'hF));
    check_eq({tag, "_tick_early"}, 32'(early), 32'(0));
    check_eq({tag, "_base15_first"}, 32'(n), 32'(114));
  endtask

  initial begin
    int quiet;
    int n;
    nRst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    check_eq("rst_tick", 32'(tick), 32'(0));
    check_eq("rst_base", 32'({base64, base15}), 32'(0));
    release_check("init");

    // Channel 1 on 64 kHz, AUDF1 = 3
    reg_wr(4'd0, 8'd3);
    reg_wr(4'd8, 8'h00);
    measure(0, 112, "ch1_base64_period");

    // Channel 2 on 15 kHz, AUDF2 = 0
    reg_wr(4'd8, 8'h01);
    reg_wr(4'd2, 8'd0);
    measure(1, 114, "ch2_base15_period");
    check_eq("ch2_base15_aligned", 32'(b15_at_tick), 32'(1));

    // Channel 1 at machine clock
    reg_wr(4'd8, 8'h40);
    reg_wr(4'd0, 8'h00);
    measure(0, 4, "ch1_fast_audf00");
    reg_wr(4'd0, 8'hFF);
    measure(0, 259, "ch1_fast_audfff");

    // Joined 1+2 at machine clock, value 0x0100
    reg_wr(4'd8, 8'h50);
    reg_wr(4'd0, 8'h00);
    reg_wr(4'd2, 8'h01);
    measure(1, 263, "join12_fast_period");
    check_eq("join12_lo_tick_quiet", 32'(lo_hits), 32'(0));

    // STIMER coincident with a ch3 underflow
    reg_wr(4'd8, 8'h60);
    reg_wr(4'd0, 8'd5);
    reg_wr(4'd4, 8'd5);
    measure(2, 9, "ch3_fast_period");
    repeat (8) @(posedge clk);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h5A;
    @(posedge clk);
    wr_en = 1'b0;
    check_eq("stimer_no_tick", 32'(tick[2]), 32'(0));
    quiet = 0;
    repeat (8) begin
      @(posedge clk);
      if (tick[2] || tick[0]) quiet++;
    end
    check_eq("stimer_quiet", 32'(quiet), 32'(0));
    @(posedge clk);
    check_eq("stimer_ch3_realigned", 32'(tick[2]), 32'(1));
    check_eq("stimer_ch1_realigned", 32'(tick[0]), 32'(1));

    // Reset asserted mid-count while base64 is high
    for (int i = 0; i < 4; i++) reg_wr(4'(2 * i), 8'h10);
    reg_wr(4'd8, 8'h00);
    repeat (40) @(posedge clk);
    n = 0;
    do begin @(posedge clk); n++; end while (!base64 && n < 100);
    check_eq("pre_reset_base64", 32'(base64), 32'(1));
    #1 nRst = 1'b0;
    #1;
    check_eq("async_rst_base64", 32'(base64), 32'(0));
    check_eq("async_rst_tick", 32'(tick), 32'(0));
    check_eq("async_rst_base15", 32'(base15), 32'(0));
    repeat (4) @(posedge clk);
    check_eq("held_rst_outputs", 32'({tick, base64, base15}), 32'(0));
    release_check("rerst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
